booking_request_dispatcher: RTL and testbench

Upstream front-end for the self-healing multi-train booking wrapper. It accepts booking requests from two ticket counters over valid/ready handshakes and rejects malformed requests at the door. Accepted requests are arbitrated round-robin into a small FIFO and issued one at a time as a single-cycle `book_req` with stable operands. It then captures the wrapper's registered result and returns it to the originating counter, stalling while a full-recovery heal is active.

---
 rtl/booking_request_dispatcher_pkg.sv | 38 +++
 rtl/booking_request_dispatcher_if.sv | 55 +++++
 rtl/booking_req_fifo.sv | 53 +++++
 rtl/booking_request_dispatcher.sv | 137 +++++++++++++
 tb/tb_booking_request_dispatcher.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/booking_request_dispatcher_pkg.sv
// Shared types and constants for the booking request dispatcher: field widths,
// the queued request record, the dispatch state enum and the request legality check.
package rtv_booking_pkg;

  localparam int TRAIN_W    = 1;
  localparam int STN_W      = 3;
  localparam int TKT_W      = 4;
  localparam int CNT_W      = 4;
  localparam int FARE_W     = 10;
  localparam int FIFO_CNT_W = 3;

  localparam logic [1:0] HEAL_FULL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_REPORT
  } disp_state_e;

  typedef struct packed {
    logic               term;
    logic [TRAIN_W-1:0] train;
    logic [STN_W-1:0]   src;
    logic [STN_W-1:0]   dest;
    logic [TKT_W-1:0]   tickets;
  } req_t;

  localparam int REQ_W = $bits(req_t);

  // Limits arrive one bit wider than the fields so every compare stays unsigned and width-matched.
  function automatic logic req_legal(input req_t r, input logic [STN_W:0] n_stn,
                                     input logic [TKT_W:0] max_tkt);
    return (r.src < r.dest) && ({1'b0, r.dest} < n_stn) &&
           (r.tickets != '0) && ({1'b0, r.tickets} <= max_tkt);
  endfunction

endpackage

// File: rtl/booking_request_dispatcher_if.sv
// Bundle of counter request, wrapper and response signals around the dispatcher.
// The slave modport is the dispatcher side; master is the surrounding environment.
interface booking_request_dispatcher_if;
  import rtv_booking_pkg::*;

  logic                  t0_valid, t0_ready, t0_reject;
  logic [TRAIN_W-1:0]    t0_train;
  logic [STN_W-1:0]      t0_src, t0_dest;
  logic [TKT_W-1:0]      t0_tickets;
  logic                  t1_valid, t1_ready, t1_reject;
  logic [TRAIN_W-1:0]    t1_train;
  logic [STN_W-1:0]      t1_src, t1_dest;
  logic [TKT_W-1:0]      t1_tickets;

  logic                  book_req;
  logic [TRAIN_W-1:0]    train_id;
  logic [STN_W-1:0]      src, dest;
  logic [TKT_W-1:0]      num_tickets;

  logic                  success;
  logic [CNT_W-1:0]      booked_count;
  logic [FARE_W-1:0]     fare;
  logic                  heal_trigger;
  logic [1:0]            heal_mode;

  logic                  resp_valid, resp_ready, resp_term, resp_success;
  logic [CNT_W-1:0]      resp_count;
  logic [FARE_W-1:0]     resp_fare;

  logic [FIFO_CNT_W-1:0] fifo_count;
  logic                  busy;

  modport master (
    output t0_valid, t0_train, t0_src, t0_dest, t0_tickets,
    output t1_valid, t1_train, t1_src, t1_dest, t1_tickets,
    input  t0_ready, t0_reject, t1_ready, t1_reject,
    input  book_req, train_id, src, dest, num_tickets,
    output success, booked_count, fare, heal_trigger, heal_mode,
    input  resp_valid, resp_term, resp_success, resp_count, resp_fare,
    output resp_ready,
    input  fifo_count, busy
  );

  modport slave (
    input  t0_valid, t0_train, t0_src, t0_dest, t0_tickets,
    input  t1_valid, t1_train, t1_src, t1_dest, t1_tickets,
    output t0_ready, t0_reject, t1_ready, t1_reject,
    output book_req, train_id, src, dest, num_tickets,
    input  success, booked_count, fare, heal_trigger, heal_mode,
    output resp_valid, resp_term, resp_success, resp_count, resp_fare,
    input  resp_ready,
    output fifo_count, busy
  );

endinterface

// File: rtl/booking_req_fifo.sv
// Synchronous FIFO with occupancy count; head is visible combinationally on o_rdat.
// Push when full and pop when empty are ignored; push and pop may coincide.
module booking_req_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_push,
  input  logic [WIDTH-1:0]               i_wdat,
  input  logic                           i_pop,
  output logic [WIDTH-1:0]               o_rdat,
  output logic [$clog2(DEPTH+1)-1:0]     o_count,
  output logic                           o_full,
  output logic                           o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push, w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign o_rdat  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/booking_request_dispatcher.sv
// Two-counter round-robin front end: validates requests, queues them and issues
// one booking at a time to the wrapper, returning the captured result to the requester.
module booking_request_dispatcher
  import rtv_booking_pkg::*;
#(
  parameter int unsigned NUM_STATIONS = 5,
  parameter int unsigned MAX_TICKETS  = 8,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned RESULT_LAT   = 2
) (
  input logic                         clk,
  input logic                         rst_n,
  booking_request_dispatcher_if.slave bus
);
  localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WCW = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;
  localparam logic [STN_W:0]   LP_NSTN      = (STN_W + 1)'(NUM_STATIONS);
  localparam logic [TKT_W:0]   LP_MAXT      = (TKT_W + 1)'(MAX_TICKETS);
  localparam logic [WCW-1:0]   LP_WAIT_LAST = WCW'(RESULT_LAT - 1);

  req_t              w_req0, w_req1, w_req_sel, r_op;
  logic [REQ_W-1:0]  w_head_dat;
  logic [FCW-1:0]    w_count;
  logic              w_gnt0, w_gnt1, w_acc0, w_acc1, w_push, w_pop, w_capture;
  logic              w_full, w_empty, w_heal_full;
  logic              r_rr_ptr, r_t0_reject, r_t1_reject;
  logic [WCW-1:0]    r_wait_cnt;
  disp_state_e       r_state, w_state_nxt;
  logic              r_resp_term, r_resp_success;
  logic [CNT_W-1:0]  r_resp_count;
  logic [FARE_W-1:0] r_resp_fare;

  assign w_req0 = {1'b0, bus.t0_train, bus.t0_src, bus.t0_dest, bus.t0_tickets};
  assign w_req1 = {1'b1, bus.t1_train, bus.t1_src, bus.t1_dest, bus.t1_tickets};

  // The pointer picks the winner only under contention; a lone requester is always granted.
  assign w_gnt0     = bus.t0_valid && (!r_rr_ptr || !bus.t1_valid);
  assign w_gnt1     = bus.t1_valid && (r_rr_ptr || !bus.t0_valid);
  assign w_acc0     = w_gnt0 && !w_full;
  assign w_acc1     = w_gnt1 && !w_full;
  assign w_req_sel  = w_acc1 ? w_req1 : w_req0;
  assign w_push     = (w_acc0 || w_acc1) && req_legal(w_req_sel, LP_NSTN, LP_MAXT);
  assign w_heal_full = bus.heal_trigger && (bus.heal_mode == HEAL_FULL);

  booking_req_fifo #(.WIDTH(REQ_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdat  (w_req_sel),
    .i_pop   (w_pop),
    .o_rdat  (w_head_dat),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= 1'b0;
      r_t0_reject <= 1'b0;
      r_t1_reject <= 1'b0;
    end else begin
      if (w_acc0)      r_rr_ptr <= 1'b1;
      else if (w_acc1) r_rr_ptr <= 1'b0;
      r_t0_reject <= w_acc0 && !req_legal(w_req0, LP_NSTN, LP_MAXT);
      r_t1_reject <= w_acc1 && !req_legal(w_req1, LP_NSTN, LP_MAXT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && !w_heal_full) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (r_wait_cnt == LP_WAIT_LAST) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_REPORT;
        end
      end
      ST_REPORT: if (bus.resp_ready) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Operands load on the pop edge and are left untouched until the next pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op           <= '0;
      r_wait_cnt     <= '0;
      r_resp_term    <= 1'b0;
      r_resp_success <= 1'b0;
      r_resp_count   <= '0;
      r_resp_fare    <= '0;
    end else begin
      if (w_pop) r_op <= req_t'(w_head_dat);
      if (r_state == ST_ISSUE)     r_wait_cnt <= '0;
      else if (r_state == ST_WAIT) r_wait_cnt <= r_wait_cnt + 1'b1;
      if (w_capture) begin
        r_resp_term    <= r_op.term;
        r_resp_success <= bus.success;
        r_resp_count   <= bus.booked_count;
        r_resp_fare    <= bus.fare;
      end
    end
  end

  assign bus.t0_ready     = w_acc0;
  assign bus.t1_ready     = w_acc1;
  assign bus.t0_reject    = r_t0_reject;
  assign bus.t1_reject    = r_t1_reject;
  assign bus.book_req     = (r_state == ST_ISSUE);
  assign bus.train_id     = r_op.train;
  assign bus.src          = r_op.src;
  assign bus.dest         = r_op.dest;
  assign bus.num_tickets  = r_op.tickets;
  assign bus.resp_valid   = (r_state == ST_REPORT);
  assign bus.resp_term    = r_resp_term;
  assign bus.resp_success = r_resp_success;
  assign bus.resp_count   = r_resp_count;
  assign bus.resp_fare    = r_resp_fare;
  assign bus.fifo_count   = FIFO_CNT_W'(w_count);
  assign bus.busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_booking_request_dispatcher.sv
// Scoreboard bench: accepted legal requests queue expected bookings and responses,
// which are popped on book_req and on the response handshake.
module tb_booking_request_dispatcher;
  import rtv_booking_pkg::*;

  localparam int RESULT_LAT = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  booking_request_dispatcher_if bus ();

  booking_request_dispatcher #(
    .NUM_STATIONS(5), .MAX_TICKETS(8), .FIFO_DEPTH(4), .RESULT_LAT(RESULT_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0, n_pass = 0;
  int cyc = 0, n_acc = 0, n_book = 0, n_rv = 0, n_rej0 = 0, n_rej1 = 0;
  int last_acc_cyc = 0, last_book_cyc = 0, first_rv_cyc = 0;
  logic exp_rej0 = 1'b0, exp_rej1 = 1'b0, prev_rv = 1'b0;
  req_t        dq[$];
  logic [15:0] rq[$];
  int          acc_log[$];
  req_t        mon_r;
  int          wr_cd = 0;
  logic [14:0] wr_val = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic req_t mk(input logic term, input logic tr, input logic [2:0] s,
                              input logic [2:0] d, input logic [3:0] k);
    return {term, tr, s, d, k};
  endfunction

  function automatic logic tb_legal(input req_t r);
    return (r.src < r.dest) && (r.dest < 3'd5) && (r.tickets >= 4'd1) && (r.tickets <= 4'd8);
  endfunction

  // Wrapper model: books succeed for up to 6 tickets; fare = 20 per station hop per ticket.
  function automatic logic [15:0] resp_of(input req_t r);
    logic       ok;
    logic [9:0] f;
    ok = (r.tickets <= 4'd6);
    f  = 10'((r.dest - r.src) * 20 * r.tickets);
    return {r.term, ok, (ok ? r.tickets : 4'd0), f};
  endfunction

  // Results are driven only in the single cycle RESULT_LAT after book_req; garbage otherwise.
  always @(negedge clk) begin
    if (!rst_n) begin
      wr_cd = 0;
      bus.success = 1'b0; bus.booked_count = '0; bus.fare = '0;
    end else begin
      if (wr_cd == 1) {bus.success, bus.booked_count, bus.fare} = wr_val;
      else begin
        bus.success = 1'b0; bus.booked_count = 4'hF; bus.fare = 10'h3FF;
      end
      if (wr_cd > 0) wr_cd--;
      if (bus.book_req) begin
        wr_cd  = RESULT_LAT;
        wr_val = 15'(resp_of(mk(1'b0, bus.train_id, bus.src, bus.dest, bus.num_tickets)));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_rej0 = 1'b0; exp_rej1 = 1'b0; prev_rv = 1'b0;
    end else begin
      if (bus.t0_reject || exp_rej0) chk("t0_reject", bus.t0_reject, exp_rej0);
      if (bus.t1_reject || exp_rej1) chk("t1_reject", bus.t1_reject, exp_rej1);
      if (bus.t0_reject) n_rej0++;
      if (bus.t1_reject) n_rej1++;
      exp_rej0 = 1'b0; exp_rej1 = 1'b0;
      if (bus.t0_valid && bus.t0_ready) begin
        mon_r = mk(1'b0, bus.t0_train, bus.t0_src, bus.t0_dest, bus.t0_tickets);
        n_acc++; last_acc_cyc = cyc; acc_log.push_back(0);
        if (tb_legal(mon_r)) begin dq.push_back(mon_r); rq.push_back(resp_of(mon_r)); end
        else exp_rej0 = 1'b1;
      end
      if (bus.t1_valid && bus.t1_ready) begin
        mon_r = mk(1'b1, bus.t1_train, bus.t1_src, bus.t1_dest, bus.t1_tickets);
        n_acc++; last_acc_cyc = cyc; acc_log.push_back(1);
        if (tb_legal(mon_r)) begin dq.push_back(mon_r); rq.push_back(resp_of(mon_r)); end
        else exp_rej1 = 1'b1;
      end
      if (bus.book_req) begin
        n_book++; last_book_cyc = cyc;
        if (dq.size() == 0) chk("book_unexpected", 1, 0);
        else begin
          mon_r = dq.pop_front();
          chk("book_ops", {bus.train_id, bus.src, bus.dest, bus.num_tickets},
              {mon_r.train, mon_r.src, mon_r.dest, mon_r.tickets});
        end
      end
      if (bus.resp_valid && !prev_rv) begin n_rv++; first_rv_cyc = cyc; end
      prev_rv = bus.resp_valid;
      if (bus.resp_valid && bus.resp_ready) begin
        if (rq.size() == 0) chk("resp_unexpected", 1, 0);
        else chk("resp", {bus.resp_term, bus.resp_success, bus.resp_count, bus.resp_fare},
                 rq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int t, input logic v, input logic tr, input logic [2:0] s,
                         input logic [2:0] d, input logic [3:0] k);
    if (t == 0) begin
      bus.t0_valid = v; bus.t0_train = tr; bus.t0_src = s; bus.t0_dest = d; bus.t0_tickets = k;
    end else begin
      bus.t1_valid = v; bus.t1_train = tr; bus.t1_src = s; bus.t1_dest = d; bus.t1_tickets = k;
    end
  endtask

  task automatic send(input int t, input logic tr, input logic [2:0] s, input logic [2:0] d,
                      input logic [3:0] k);
    logic ok = 1'b0;
    int   n  = 0;
    set_req(t, 1'b1, tr, s, d, k);
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = (t == 0) ? bus.t0_ready : bus.t1_ready;
      tick();
      n++;
    end
    if (t == 0) bus.t0_valid = 1'b0; else bus.t1_valid = 1'b0;
    chk("send_accepted", ok, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((bus.busy || dq.size() != 0 || rq.size() != 0) && n < 300) begin tick(); n++; end
    chk({tag, "_drained"}, (!bus.busy && dq.size() == 0 && rq.size() == 0), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the bench finished");
    $fatal(1);
  end

  initial begin
    int b0, r0, a0, rv0, n, hcyc, off;
    set_req(0, 1'b0, 1'b0, 3'd0, 3'd0, 4'd0);
    set_req(1, 1'b0, 1'b0, 3'd0, 3'd0, 4'd0);
    bus.resp_ready = 1'b0; bus.heal_trigger = 1'b0; bus.heal_mode = 2'b00;
    #2;
    chk("rst_ctl", {bus.book_req, bus.busy, bus.resp_valid, bus.t0_ready, bus.t1_ready,
                    bus.t0_reject, bus.t1_reject, bus.fifo_count}, 0);
    chk("rst_ops", {bus.train_id, bus.src, bus.dest, bus.num_tickets, bus.resp_term,
                    bus.resp_success, bus.resp_count, bus.resp_fare}, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    bus.resp_ready = 1'b1;
    tick();

    // Single legal request and latency.
    send(0, 1'b1, 3'd0, 3'd3, 4'd2);
    wait_idle("single");
    chk("book_latency", last_book_cyc - last_acc_cyc, 2);
    chk("resp_latency", first_rv_cyc - last_book_cyc, RESULT_LAT + 1);

    // Malformed requests from t1.
    b0 = n_book; r0 = n_rej1;
    send(1, 1'b0, 3'd3, 3'd2, 4'd1);
    send(1, 1'b0, 3'd1, 3'd2, 4'd0);
    send(1, 1'b0, 3'd1, 3'd5, 4'd2);
    repeat (3) tick();
    chk("illegal_rejects", n_rej1 - r0, 3);
    chk("illegal_no_book", n_book - b0, 0);
    chk("illegal_fifo_count", bus.fifo_count, 0);

    // Legal boundaries: last station, MAX_TICKETS, and an unsuccessful booking.
    send(0, 1'b1, 3'd0, 3'd4, 4'd8);
    send(1, 1'b0, 3'd2, 3'd4, 4'd7);
    wait_idle("boundary");

    // Contention with backpressure: 1 in flight plus 4 queued.
    bus.resp_ready = 1'b0;
    acc_log.delete();
    set_req(0, 1'b1, 1'b0, 3'd1, 3'd4, 4'd3);
    set_req(1, 1'b1, 1'b1, 3'd0, 3'd2, 4'd5);
    repeat (20) tick();
    chk("cont_grant_count", acc_log.size(), 5);
    for (int i = 0; i < acc_log.size() && i < 5; i++) chk("cont_grant_order", acc_log[i], i % 2);
    chk("cont_ready_low", {bus.t0_ready, bus.t1_ready}, 0);
    chk("cont_fifo_full", bus.fifo_count, 4);
    set_req(0, 1'b0, 1'b0, 3'd0, 3'd0, 4'd0);
    set_req(1, 1'b0, 1'b0, 3'd0, 3'd0, 4'd0);
    bus.resp_ready = 1'b1;
    wait_idle("contention");

    // Full-recovery heal stalls issue.
    bus.heal_trigger = 1'b1; bus.heal_mode = 2'b11;
    hcyc = cyc; b0 = n_book;
    send(0, 1'b0, 3'd0, 3'd1, 4'd1);
    send(1, 1'b1, 3'd2, 3'd4, 4'd6);
    while (cyc < hcyc + 5) tick();
    chk("heal_no_book", n_book - b0, 0);
    chk("heal_queued", bus.fifo_count, 2);
    bus.heal_trigger = 1'b0; bus.heal_mode = 2'b00;
    off = cyc;
    repeat (2) tick();
    chk("heal_resume_cycle", last_book_cyc, off + 1);
    wait_idle("heal_full");

    // Non-full heal during WAIT and response hold under backpressure.
    bus.resp_ready = 1'b0;
    b0 = n_book; n = 0;
    send(0, 1'b1, 3'd1, 3'd3, 4'd4);
    while (n_book == b0 && n < 50) begin tick(); n++; end
    chk("heal01_booked", n_book - b0, 1);
    bus.heal_trigger = 1'b1; bus.heal_mode = 2'b01;
    n = 0;
    while (!bus.resp_valid && n < 20) begin tick(); n++; end
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_valid", bus.resp_valid, 1);
      if (rq.size() != 0)
        chk("hold_fields", {bus.resp_term, bus.resp_success, bus.resp_count, bus.resp_fare}, rq[0]);
    end
    bus.heal_trigger = 1'b0; bus.heal_mode = 2'b00;
    bus.resp_ready = 1'b1;
    wait_idle("heal01");

    // Reset while WAIT with 3 requests queued.
    a0 = n_acc; n = 0;
    set_req(0, 1'b1, 1'b1, 3'd0, 3'd4, 4'd1);
    set_req(1, 1'b1, 1'b1, 3'd1, 3'd2, 4'd2);
    while (n_acc < a0 + 4 && n < 50) begin tick(); n++; end
    set_req(0, 1'b0, 1'b0, 3'd0, 3'd0, 4'd0);
    set_req(1, 1'b0, 1'b0, 3'd0, 3'd0, 4'd0);
    chk("prereset_busy", bus.busy, 1);
    chk("prereset_queued", bus.fifo_count, 3);
    rst_n = 1'b0;
    #1;
    chk("midrst_ctl", {bus.book_req, bus.busy, bus.resp_valid, bus.t0_ready, bus.t1_ready,
                       bus.t0_reject, bus.t1_reject, bus.fifo_count}, 0);
    chk("midrst_ops", {bus.train_id, bus.src, bus.dest, bus.num_tickets, bus.resp_term,
                       bus.resp_success, bus.resp_count, bus.resp_fare}, 0);
    dq.delete(); rq.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    rv0 = n_rv; b0 = n_book;
    repeat (20) tick();
    chk("postrst_no_resp", n_rv - rv0, 0);
    chk("postrst_no_book", n_book - b0, 0);
    chk("postrst_fifo", bus.fifo_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
